// File: rtl/serial_shift_unit.sv
// serial_shift_unit: bit-serial shift engine producing the same result as the
// single-cycle barrel shifter, one position (or two, see below) per clock.
//
// Ports:
//   clk_i    - clock, all state updates on the rising edge
//   rst_i    - synchronous active-high reset
//   start_i  - request, accepted when not shifting (IDLE or DONE)
//   in_i     - 16-bit operand, captured on accept
//   cnt_i    - 4-bit shift amount, captured on accept
//   op_i     - 3-bit op: 0 ROL, 1 SLL, 2 ROR, 3 SRL, 4 SRA, 5..7 illegal
//   busy_o   - shifting and not yet on the final step
//   done_o   - one-cycle pulse, out_o valid
//   out_o    - result register, held until the next result
//   err_o    - with done_o when the captured op was illegal
//
// Build option: define SERIAL_SHIFT_DOUBLE_EN to shift two positions per
// cycle while two or more remain.
module serial_shift_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] in_i,
  input  logic [3:0]  cnt_i,
  input  logic [2:0]  op_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] out_o,
  output logic        err_o
);

  localparam int unsigned DataW = 16;
  localparam int unsigned CntW  = 4;
  localparam int unsigned OpW   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DataW-1:0]  acc_q, acc_d;
  logic [DataW-1:0]  out_q, out_d;
  logic [CntW-1:0]   rem_q, rem_d;
  logic [OpW-1:0]    op_q, op_d;
  logic              byp_q, byp_d;
  logic              accept;
  logic              last_step;

  function automatic logic op_legal(input logic [OpW-1:0] op);
    return op <= OpW'(4);
  endfunction

  // One-position step.
  function automatic logic [DataW-1:0] step1(input logic [OpW-1:0] op,
                                             input logic [DataW-1:0] a);
    case (op)
      3'd0:    return {a[14:0], a[15]};
      3'd1:    return {a[14:0], 1'b0};
      3'd2:    return {a[0], a[15:1]};
      3'd3:    return {1'b0, a[15:1]};
      3'd4:    return {a[15], a[15:1]};
      default: return a;
    endcase
  endfunction

`ifdef SERIAL_SHIFT_DOUBLE_EN
  // Two-position step.
  function automatic logic [DataW-1:0] step2(input logic [OpW-1:0] op,
                                             input logic [DataW-1:0] a);
    case (op)
      3'd0:    return {a[13:0], a[15:14]};
      3'd1:    return {a[13:0], 2'b00};
      3'd2:    return {a[1:0], a[15:2]};
      3'd3:    return {2'b00, a[15:2]};
      3'd4:    return {{2{a[15]}}, a[15:2]};
      default: return a;
    endcase
  endfunction
`endif

  // A request is taken whenever no shift is in flight, including the DONE cycle.
  assign accept = start_i && (state_q != ST_SHIFT);

  // Bypass ops (count 0 or illegal) spend a single non-busy SHIFT cycle so
  // their latency matches a one-position shift.
`ifdef SERIAL_SHIFT_DOUBLE_EN
  assign last_step = byp_q || (rem_q <= CntW'(2));
`else
  assign last_step = byp_q || (rem_q == CntW'(1));
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SHIFT;
      ST_SHIFT: if (last_step) state_d = ST_DONE;
      ST_DONE:  state_d = start_i ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from state registers only.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    err_o  = 1'b0;
    case (state_q)
      ST_SHIFT: busy_o = !last_step;
      ST_DONE: begin
        done_o = 1'b1;
        err_o  = !op_legal(op_q);
      end
      default: ;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    op_d  = op_q;
    byp_d = byp_q;
    out_d = out_q;
    if (accept) begin
      acc_d = in_i;
      rem_d = cnt_i;
      op_d  = op_i;
      byp_d = (cnt_i == CntW'(0)) || !op_legal(op_i);
      if (byp_d) out_d = in_i;
    end else if (state_q == ST_SHIFT && !byp_q) begin
`ifdef SERIAL_SHIFT_DOUBLE_EN
      if (rem_q >= CntW'(2)) begin
        acc_d = step2(op_q, acc_q);
        rem_d = rem_q - CntW'(2);
      end else begin
        acc_d = step1(op_q, acc_q);
        rem_d = rem_q - CntW'(1);
      end
`else
      acc_d = step1(op_q, acc_q);
      rem_d = rem_q - CntW'(1);
`endif
      if (last_step) out_d = acc_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      rem_q <= '0;
      op_q  <= '0;
      byp_q <= 1'b0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      rem_q <= rem_d;
      op_q  <= op_d;
      byp_q <= byp_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Self-checking bench for serial_shift_unit: directed cases plus a randomized
// cross-check against an arithmetic model of the barrel shifter.
module tb_serial_shift_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] in_i;
  logic [3:0]  cnt_i;
  logic [2:0]  op_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] out_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  serial_shift_unit dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .in_i    (in_i),
    .cnt_i   (cnt_i),
    .op_i    (op_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .out_o   (out_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Barrel shifter reference in plain arithmetic.
  function automatic logic [15:0] ref_shift(input logic [15:0] a, input int n,
                                            input logic [2:0] op);
    int unsigned x;
    logic signed [15:0] s;
    x = 32'(a);
    s = a;
    case (op)
      3'd0:    return 16'((x << n) | (x >> (16 - n)));
      3'd1:    return 16'(x << n);
      3'd2:    return 16'((x >> n) | (x << (16 - n)));
      3'd3:    return 16'(x >> n);
      3'd4:    return 16'(s >>> n);
      default: return a;
    endcase
  endfunction

  // Edges from accept to the edge after which done is high.
  function automatic int ref_lat(input int n, input logic [2:0] op);
    if (n == 0 || op > 3'd4) return 1;
`ifdef SERIAL_SHIFT_DOUBLE_EN
    return (n + 1) / 2;
`else
    return n;
`endif
  endfunction

  // Present a request and clock the accept edge.
  task automatic issue(input logic [15:0] a, input logic [3:0] n, input logic [2:0] op);
    in_i    = a;
    cnt_i   = n;
    op_i    = op;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Wait (bounded) for done after an accept; optionally pulse stray starts while busy.
  task automatic wait_done(input string tag, input logic [15:0] e_out, input logic e_err,
                           input int e_lat, input bit noise);
    int cyc = 0;
    int bsy = 0;
    while (done_o !== 1'b1 && cyc < 64) begin
      if (busy_o === 1'b1) bsy++;
      if (noise && busy_o === 1'b1) begin
        start_i = 1'b1;
        in_i    = 16'($urandom);
        cnt_i   = 4'($urandom);
        op_i    = 3'($urandom);
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    start_i = 1'b0;
    check({tag, "_lat"},  32'(cyc), 32'(e_lat));
    check({tag, "_out"},  32'(out_o), 32'(e_out));
    check({tag, "_err"},  32'(err_o), 32'(e_err));
    check({tag, "_busy"}, 32'(bsy), 32'(e_lat - 1));
  endtask

  task automatic done_drops(input string tag);
    @(posedge clk_i); #1;
    check({tag, "_pulse"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    time t1;
    int dn;
    int bc;
    logic [15:0] a;
    logic [3:0]  n;
    logic [2:0]  op;

    rst_i = 1'b1; start_i = 1'b0; in_i = '0; cnt_i = '0; op_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check("rst_out",  32'(out_o),  32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_err",  32'(err_o),  32'h0);
    dn = 0;
    repeat (6) begin @(posedge clk_i); #1; if (done_o !== 1'b0) dn++; end
    check("idle_done", 32'(dn), 32'd0);

    // SRA 8001 >>> 4
    issue(16'h8001, 4'd4, 3'd4);
    wait_done("sra", 16'hF800, 1'b0, ref_lat(4, 3'd4), 1'b0);
    done_drops("sra");

    // ROL 1234 by 15, stray starts during busy
    issue(16'h1234, 4'd15, 3'd0);
    wait_done("rol", 16'h091A, 1'b0, ref_lat(15, 3'd0), 1'b1);
    done_drops("rol");

    // count zero
    issue(16'hABCD, 4'd0, 3'd1);
    wait_done("cnt0", 16'hABCD, 1'b0, 1, 1'b0);
    done_drops("cnt0");

    // illegal op
    issue(16'h5A5A, 4'd5, 3'd6);
    wait_done("ill", 16'h5A5A, 1'b1, 1, 1'b0);
    done_drops("ill");

    // back-to-back: next request accepted in the DONE cycle
    issue(16'h8000, 4'd3, 3'd3);
    wait_done("b2b_a", 16'h1000, 1'b0, ref_lat(3, 3'd3), 1'b0);
    t1 = $time;
    issue(16'h0001, 4'd2, 3'd1);
    wait_done("b2b_b", 16'h0004, 1'b0, ref_lat(2, 3'd1), 1'b0);
    check("b2b_gap", 32'(($time - t1) / 10), 32'(ref_lat(2, 3'd1) + 1));
    done_drops("b2b");

    // reset in the 3rd busy cycle of ROR 00FF by 8
    issue(16'h00FF, 4'd8, 3'd2);
    bc = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy_o === 1'b1) bc++;
      if (bc == 3) break;
      @(posedge clk_i); #1;
    end
    check("mid_busy_seen", 32'(bc), 32'd3);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("mid_out",  32'(out_o),  32'h0);
    check("mid_busy", 32'(busy_o), 32'h0);
    check("mid_done", 32'(done_o), 32'h0);
    dn = 0;
    repeat (12) begin @(posedge clk_i); #1; if (done_o !== 1'b0) dn++; end
    check("mid_nodone", 32'(dn), 32'd0);
    issue(16'h00FF, 4'd8, 3'd2);
    wait_done("mid_next", 16'hFF00, 1'b0, ref_lat(8, 3'd2), 1'b0);

    // randomized cross-check, legal ops
    for (int i = 0; i < 1000; i++) begin
      a  = 16'($urandom);
      n  = 4'($urandom_range(0, 15));
      op = 3'($urandom_range(0, 4));
      issue(a, n, op);
      wait_done("rnd", ref_shift(a, int'(n), op), 1'b0, ref_lat(int'(n), op), i[0]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
